// File: rtl/fft_sched.sv
// fft_sched: in-place radix-2 DIT FFT schedule for one pipelined BFU.
// Optional cycle counter port enabled by defining FFT_SCHED_CYCLE_CNT_EN.
module fft_sched #(
  parameter int N_LOG2  = 6,
  parameter int RD_LAT  = 1,
  parameter int BFU_LAT = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        hold,
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(N_LOG2)-1:0]   stage,
  output logic                        rd_en,
  output logic [N_LOG2-1:0]           rd_addr_a,
  output logic [N_LOG2-1:0]           rd_addr_b,
  output logic [N_LOG2-2:0]           tw_addr,
  output logic                        bfu_en,
  output logic                        wr_en,
  output logic [N_LOG2-1:0]           wr_addr_a,
  output logic [N_LOG2-1:0]           wr_addr_b
`ifdef FFT_SCHED_CYCLE_CNT_EN
  ,
  output logic [15:0]                 cycle_cnt
`endif
);

  localparam int AW   = N_LOG2;
  localparam int KW   = N_LOG2 - 1;
  localparam int SW   = $clog2(N_LOG2);
  localparam int PIPE = RD_LAT + BFU_LAT;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [KW-1:0] k_q, k_d;
  logic busy_q, done_q, issue_q;

  logic [PIPE-1:0] pv_q, pv_d;
  logic [PIPE-1:0][2*AW-1:0] pa_q, pa_d;

  logic [AW-1:0] k_ext, half, j, hi;
  logic [AW-1:0] a, b;
  logic [KW-1:0] tw;
  logic drain_ok;

  // butterfly k of stage s: pair indices and twiddle exponent
  always_comb begin
    k_ext = AW'(k_q);
    half  = AW'(1) << s_q;
    j     = k_ext & (half - AW'(1));
    hi    = (k_ext >> s_q) << s_q;
    a     = (hi << 1) | j;
    b     = a | half;
    tw    = '0;
    for (int i = 0; i < N_LOG2; i++) begin
      if (s_q == SW'(i)) tw = KW'(j << (N_LOG2 - 1 - i));
    end
  end

  assign rd_en     = issue_q & ~hold;
  assign rd_addr_a = issue_q ? a  : '0;
  assign rd_addr_b = issue_q ? b  : '0;
  assign tw_addr   = issue_q ? tw : '0;
  assign bfu_en    = busy_q & ~hold;
  assign busy      = busy_q;
  assign done      = done_q;
  assign stage     = s_q;

  assign wr_en     = pv_q[PIPE-1] & ~hold;
  assign wr_addr_a = pv_q[PIPE-1] ? pa_q[PIPE-1][2*AW-1:AW] : '0;
  assign wr_addr_b = pv_q[PIPE-1] ? pa_q[PIPE-1][AW-1:0]    : '0;

  // only the tail entry may remain; it retires this cycle
  assign drain_ok = (pv_q[PIPE-2:0] == '0);

  // next-state, counters and write-back delay line
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    pv_d    = pv_q;
    pa_d    = pa_q;
    if (!hold) begin
      pv_d = {pv_q[PIPE-2:0], rd_en};
      pa_d = {pa_q[PIPE-2:0], {rd_addr_a, rd_addr_b}};
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = ISSUE;
            s_d     = '0;
            k_d     = '0;
          end
        end
        ISSUE: begin
          if (&k_q) begin
            state_d = DRAIN;
            k_d     = '0;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
        DRAIN: begin
          if (drain_ok) begin
            if (s_q == SW'(N_LOG2 - 1)) begin
              state_d = DONE;
            end else begin
              state_d = ISSUE;
              s_d     = s_q + SW'(1);
            end
          end
        end
        DONE: begin
          state_d = IDLE;
          s_d     = '0;
        end
      endcase
    end
  end

  // schedule FSM with registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      issue_q <= 1'b0;
      pv_q    <= '0;
      pa_q    <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      busy_q  <= (state_d == ISSUE) || (state_d == DRAIN);
      done_q  <= (state_d == DONE);
      issue_q <= (state_d == ISSUE);
      pv_q    <= pv_d;
      pa_q    <= pa_d;
    end
  end

`ifdef FFT_SCHED_CYCLE_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // busy-cycle count, cleared by an accepted start, saturating
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE && start && !hold) begin
      cnt_d = '0;
    end else if (busy_q && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // cycle counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cycle_cnt = cnt_q;
`endif

endmodule
